seq_adder_ctrl: RTL and testbench
=================================

SEQ_ADDER_CTRL -- requirements
Module: seq_adder_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTH, default 100, meaning the total operand width in bits.
REQ-002 The block SHALL have parameter CHUNK, default 25, meaning the bits added per cycle; WIDTH SHALL be an integer multiple of CHUNK; NCH = WIDTH/CHUNK.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand request.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have ports a and b, input, WIDTH bits each: the addends.
REQ-008 The block SHALL have port cin, input, 1 bit: the carry-in.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result is available.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-011 The block SHALL have port sum, output, WIDTH bits: the result, equal to (a+b+cin) mod 2^WIDTH.
REQ-012 The block SHALL have port cout, output, 1 bit: the carry-out of the MSB.
REQ-013 The block SHALL have port busy, output, 1 bit: high in the RUN state.

Function
REQ-014 The FSM SHALL have states IDLE, RUN and DONE; in_ready = (state==IDLE); out_valid = (state==DONE); busy = (state==RUN).
REQ-015 IDLE: when in_valid is high at an edge, the block SHALL register a, b and cin, clear the chunk index idx to 0, and go to RUN; otherwise it stays in IDLE.
REQ-016 RUN: on each edge, the block SHALL add chunk idx of a and b plus the carry register, write the result into sum[idx*CHUNK +: CHUNK], load the chunk carry-out into the carry register, and increment idx.
REQ-017 RUN: on the edge where idx==NCH-1, the block SHALL set cout to the final carry and go to DONE.
REQ-018 Latency: out_valid SHALL assert exactly NCH edges after the accepting edge, which is 4 cycles at default parameters.
REQ-019 DONE: sum and cout SHALL remain stable until an edge where out_ready is high; on that edge the block goes to IDLE.
REQ-020 There SHALL be no overlap: in_valid is ignored outside IDLE, and a new operand can be accepted no earlier than the edge after the result handshake, giving a minimum period of NCH+2 cycles.
REQ-021 Operands SHALL be sampled only at the accept edge; changes on a, b or cin during RUN or DONE SHALL NOT affect the result.
REQ-022 The idx counter SHALL be $clog2(NCH) bits wide and SHALL never exceed NCH-1.
REQ-023 A carry out of chunk k SHALL propagate into chunk k+1 on the next cycle, with no loss at chunk boundaries.

Reset
REQ-024 When rst is high at an edge, the block SHALL set the state to IDLE and clear idx, the carry register, sum, cout and the operand registers to 0, regardless of the current state; this includes aborting RUN and DONE mid-operation.
REQ-025 During and after reset, the outputs SHALL be: in_ready=1 (from the first edge after rst is released), out_valid=0, busy=0, sum=0, cout=0.
REQ-026 rst SHALL take priority over in_valid and out_ready on the same edge.

Structure
REQ-027 A shared package seq_adder_pkg SHALL hold the state enum (IDLE, RUN, DONE) and the default WIDTH and CHUNK constants.
REQ-028 The chunk arithmetic SHALL be one combinational sub-module, chunk_adder (CHUNK-bit ripple-carry: a, b, cin -> sum, cout), instantiated once and reused every RUN cycle.

Verification
REQ-029 a=all-ones, b=0, cin=1, out_ready=1 -> after 4 cycles: sum=0, cout=1, out_valid for 1 cycle.
REQ-030 a=0, b=0, cin=1 -> sum=1, cout=0; busy is high for exactly 4 cycles.
REQ-031 a=2^25-1, b=1, cin=0 -> sum=2^25, cout=0, which checks the chunk-0 to chunk-1 boundary.
REQ-032 out_ready is held low for 10 cycles after out_valid rises -> sum and cout stay constant and in_ready=0 throughout; in_valid pulses are ignored.
REQ-033 rst is asserted on the 2nd RUN cycle -> on the next edge state=IDLE and sum=0; a following operand pair a=5, b=7 yields sum=12.
REQ-034 Random regression: 1000 back-to-back transactions with random out_ready -> each sum and cout matches a reference model; accepts and results are equal in count and order.

Source files
------------

// File: rtl/seq_adder_pkg.sv
// Shared definitions for the chunked sequential adder: FSM state encoding
// and the default operand/chunk geometry.
package seq_adder_pkg;

  localparam int DEF_WIDTH = 100;
  localparam int DEF_CHUNK = 25;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/seq_adder_ctrl_if.sv
// Operand/result handshake bundle for seq_adder_ctrl. The master supplies
// operands and consumes results; the slave is the adder itself.
interface seq_adder_ctrl_if #(
  parameter int WIDTH = seq_adder_pkg::DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;

  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, sum, cout, busy
  );

  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, sum, cout, busy
  );

endinterface

// File: rtl/seq_adder_ctrl_chunk_adder.sv
// CHUNK-bit ripple-carry adder, purely combinational. The controller reuses
// one instance for every chunk of the wide operands.
module chunk_adder #(
  parameter int CHUNK = seq_adder_pkg::DEF_CHUNK
) (
  input  logic [CHUNK-1:0] a_i,
  input  logic [CHUNK-1:0] b_i,
  input  logic             cin_i,
  output logic [CHUNK-1:0] sum_o,
  output logic             cout_o
);

  logic [CHUNK:0] carry;

  assign carry[0] = cin_i;

  // One full-adder cell per bit; carry ripples from LSB to MSB.
  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    assign sum_o[i]    = a_i[i] ^ b_i[i] ^ carry[i];
    assign carry[i+1]  = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
  end

  assign cout_o = carry[CHUNK];

endmodule

// File: rtl/seq_adder_ctrl.sv
// Sequential wide adder: captures a, b, cin on accept, then adds one CHUNK
// per cycle (LSB chunk first), carrying between chunks through carry_q.
// The result is held in DONE until the consumer takes it.
module seq_adder_ctrl
  import seq_adder_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CHUNK = DEF_CHUNK
) (
  input logic             clk,
  input logic             rst,
  seq_adder_ctrl_if.slave bus
);

  localparam int NCH   = WIDTH / CHUNK;
  localparam int IDX_W = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NCH - 1);

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q,   idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q,     a_d;
  logic [WIDTH-1:0] b_q,     b_d;
  logic [WIDTH-1:0] sum_q,   sum_d;
  logic             cout_q,  cout_d;

  logic [CHUNK-1:0] ch_sum;
  logic             ch_cout;

  chunk_adder #(.CHUNK(CHUNK)) u_chunk (
    .a_i    (a_q[idx_q*CHUNK +: CHUNK]),
    .b_i    (b_q[idx_q*CHUNK +: CHUNK]),
    .cin_i  (carry_q),
    .sum_o  (ch_sum),
    .cout_o (ch_cout)
  );

  // Next-state: accept in IDLE, one chunk per cycle in RUN, hold in DONE.
  always_comb begin
    // NOTE: every signal gets its hold value first, so no path infers a latch.
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    cout_d  = cout_q;
    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_d     = bus.a;
          b_d     = bus.b;
          carry_d = bus.cin;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        sum_d[idx_q*CHUNK +: CHUNK] = ch_sum;
        carry_d                     = ch_cout;
        if (idx_q == LAST_IDX) begin
          cout_d  = ch_cout;
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous reset taking priority over everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      // NOTE: operand and result registers are cleared as well, because
      // sum/cout must read 0 after reset, even when aborting mid-operation.
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking so every register updates from pre-edge values.
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.busy      = (state_q == RUN);
  assign bus.sum       = sum_q;
  assign bus.cout      = cout_q;

endmodule

// File: tb/tb_seq_adder_ctrl.sv
// Self-checking bench for seq_adder_ctrl at default geometry: directed
// vector table, handshake/reset corner sequences and a random regression
// against a plain-arithmetic reference model.
module tb_seq_adder_ctrl;

  localparam int W = 100;

  logic clk;
  logic rst;

  seq_adder_ctrl_if #(.WIDTH(W)) bus ();

  seq_adder_ctrl #(.WIDTH(W), .CHUNK(25)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  function automatic logic [W-1:0] rand_w();
    logic [127:0] t;
    int unsigned  mode;
    mode = $urandom_range(0, 7);
    t    = {$urandom, $urandom, $urandom, $urandom};
    if (mode == 0) t = '1;
    else if (mode == 1) t = '0;
    return t[W-1:0];
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Accept one operand pair, scramble inputs during RUN, wait for out_valid.
  task automatic run_txn(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input logic tcin,
                         output logic [W-1:0] rs, output logic rc,
                         output int lat, output int bcnt);
    int guard;
    guard = 0;
    while (!bus.in_ready && guard < 20) begin
      step();
      guard++;
    end
    bus.a         = ta;
    bus.b         = tb_v;
    bus.cin       = tcin;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    bus.a        = ~ta;
    bus.b        = ~tb_v;
    bus.cin      = ~tcin;
    lat  = 0;
    bcnt = 0;
    while (!bus.out_valid && lat < 20) begin
      if (bus.busy) bcnt++;
      step();
      lat++;
    end
    rs = bus.sum;
    rc = bus.cout;
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    step();
    bus.out_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
  } vec_t;

  vec_t vecs[7];

  initial begin
    logic [W-1:0] one, ones, zero, rs, snap_sum;
    logic         rc, snap_cout;
    int           lat, bcnt, bad;
    int           accepts, results, cyc;
    logic [W:0]   expq[$];
    logic [W:0]   exp_v;

    one  = 1;
    ones = '1;
    zero = '0;

    vecs[0] = '{"ones_plus_cin", ones, zero, 1'b1, zero, 1'b1};
    vecs[1] = '{"zero_plus_cin", zero, zero, 1'b1, one, 1'b0};
    vecs[2] = '{"chunk0_to_1", (one << 25) - one, one, 1'b0, one << 25, 1'b0};
    vecs[3] = '{"ones_ones_cin", ones, ones, 1'b1, ones, 1'b1};
    vecs[4] = '{"chunk2_to_3", (one << 75) - one, one, 1'b0, one << 75, 1'b0};
    vecs[5] = '{"msb_overflow", one << 99, one << 99, 1'b0, zero, 1'b1};
    vecs[6] = '{"double_ripple", (one << 50) - one, one, 1'b0, one << 50, 1'b0};

    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.cin       = 1'b0;

    // Reset state.
    rst = 1'b1;
    step();
    step();
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_sum", bus.sum, 0);
    check("rst_cout", bus.cout, 0);
    rst = 1'b0;
    step();
    check("rst_in_ready", bus.in_ready, 1);

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      run_txn(vecs[i].a, vecs[i].b, vecs[i].cin, rs, rc, lat, bcnt);
      check({vecs[i].name, "_sum"}, rs, vecs[i].sum);
      check({vecs[i].name, "_cout"}, rc, vecs[i].cout);
      check({vecs[i].name, "_latency"}, lat, 4);
      check({vecs[i].name, "_busy_cycles"}, bcnt, 4);
      handshake();
      check({vecs[i].name, "_valid_one_cycle"}, {bus.out_valid, bus.in_ready}, 2'b01);
    end

    // Consumer stalls 10 cycles; result and in_ready must hold, in_valid ignored.
    run_txn(100'd123456789, 100'd987654321, 1'b1, rs, rc, lat, bcnt);
    snap_sum  = bus.sum;
    snap_cout = bus.cout;
    bad = 0;
    for (int k = 0; k < 10; k++) begin
      bus.in_valid = k[0];
      bus.a        = rand_w();
      bus.b        = rand_w();
      step();
      if (bus.sum !== snap_sum || bus.cout !== snap_cout || bus.in_ready !== 1'b0 ||
          bus.out_valid !== 1'b1) bad++;
    end
    check("stall_hold_stable", bad, 0);
    check("stall_sum", snap_sum, 100'd1111111111);
    check("stall_cout", snap_cout, 0);
    // in_valid high on the handshake edge must not start a new operation.
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("no_overlap_idle", {bus.busy, bus.in_ready}, 2'b01);
    step();
    check("no_overlap_stays_idle", {bus.busy, bus.in_ready}, 2'b01);

    // Reset on the 2nd RUN cycle aborts the operation.
    bus.a        = 100'd123;
    bus.b        = 100'd456;
    bus.cin      = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    check("pre_abort_busy", bus.busy, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_run_state", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    check("abort_run_sum", bus.sum, 0);
    check("abort_run_cout", bus.cout, 0);
    run_txn(100'd5, 100'd7, 1'b0, rs, rc, lat, bcnt);
    check("after_abort_sum", rs, 12);
    check("after_abort_cout", rc, 0);

    // Reset while holding a result in DONE.
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("abort_done_state", {bus.in_ready, bus.busy, bus.out_valid}, 3'b100);
    check("abort_done_sum", bus.sum, 0);

    // Random back-to-back regression against {cout,sum} = a + b + cin.
    accepts = 0;
    results = 0;
    cyc     = 0;
    while (results < 1000 && cyc < 40000) begin
      bus.in_valid  = (accepts < 1000) && ($urandom_range(0, 3) != 0);
      bus.a         = rand_w();
      bus.b         = rand_w();
      bus.cin       = 1'($urandom_range(0, 1));
      bus.out_ready = 1'($urandom_range(0, 1));
      if (bus.in_valid && bus.in_ready) begin
        expq.push_back((W+1)'(bus.a) + (W+1)'(bus.b) + (W+1)'(bus.cin));
        accepts++;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (expq.size() == 0) begin
          check("rand_unexpected_result", 1, 0);
        end else begin
          exp_v = expq.pop_front();
          check("rand_result", {bus.cout, bus.sum}, exp_v);
        end
        results++;
      end
      step();
      cyc++;
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    check("rand_results_count", results, 1000);
    check("rand_accepts_match", accepts, results);
    check("rand_queue_empty", expq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
